xor_shift_inv: RTL



---
 rtl/xor_shift_inv_if.sv | 21 ++
 rtl/xor_shift_inv.sv | 108 ++++++++++
 2 files changed

// File: rtl/xor_shift_inv_if.sv
// Request/result bundle for the xor_shift inverse block.
// The master drives a word and key; the slave returns the recovered word and check flag.
interface xor_shift_inv_if;
  logic        start;
  logic [31:0] H_in;
  logic [3:0]  S;
  logic        busy;
  logic        done;
  logic [31:0] H_out;
  logic        chk_err;

  modport master (
    output start, H_in, S,
    input  busy, done, H_out, chk_err
  );

  modport slave (
    input  start, H_in, S,
    output busy, done, H_out, chk_err
  );
endinterface

// File: rtl/xor_shift_inv.sv
// Sequential inverse of the xor_shift round: recovers nibbles 1..7 one per clock,
// then checks that nibble 7 of the processed word is consistent with nibble 0.
module xor_shift_inv (
  input  logic             clk,
  input  logic             rst,
  xor_shift_inv_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] f_q, f_d;
  logic [3:0]  s_q, s_d;
  logic [31:0] h_q, h_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [3:0]  f_nib;

  function automatic logic [3:0] rotr4(input logic [3:0] x, input logic [1:0] r);
    case (r)
      2'd0:    rotr4 = x;
      2'd1:    rotr4 = {x[0],   x[3:1]};
      2'd2:    rotr4 = {x[1:0], x[3:2]};
      default: rotr4 = {x[2:0], x[3]};
    endcase
  endfunction

  assign f_nib = f_q[{k_q, 2'b00} +: 4];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    f_d     = f_q;
    s_d     = s_q;
    h_d     = h_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          f_d     = bus.H_in;
          s_d     = bus.S;
          h_d     = '0;
          err_d   = 1'b0;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        k_d = k_q + 3'd1;
        if (k_q != 3'd7) begin
          // Result nibble k+1 from f_k; rotation amount is floor(k/2) = k[2:1].
          h_d[{k_q + 3'd1, 2'b00} +: 4] = rotr4(f_nib, k_q[2:1]) ^ s_q;
        end else begin
          // rotl4 by 3 equals rotr4 by 1.
          err_d   = (f_q[31:28] != rotr4(f_q[3:0] ^ s_q, 2'd1));
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      f_q     <= '0;
      s_q     <= '0;
      h_q     <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      f_q     <= f_d;
      s_q     <= s_d;
      h_q     <= h_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.H_out   = h_q;
  assign bus.chk_err = err_q;

endmodule
